// File: rtl/rvv_backend_alu_unit_mask_viota_seq.sv
// rvv_backend_alu_unit_mask_viota_seq
//   Sequential viota.m / vid.v unit. One request carries a whole mask
//   register; results leave CHUNK elements per beat through a registered
//   output stage. Each viota element result is the running count of active
//   set source bits below it. vid reports the element index instead.
//
//   Handshake (both ports): a transfer happens on a rising clk edge where
//   valid && ready are both 1. A producer holding valid keeps its payload
//   stable until the transfer. On the output side out_* never change while
//   out_valid && !out_ready. in_ready does not depend on in_valid.
module rvv_backend_alu_unit_mask_viota_seq #(
    parameter int VLEN  = 128,
    parameter int CHUNK = 32,
    localparam int CNTW = $clog2(VLEN) + 1,
    localparam int LOGC = $clog2(CHUNK),
    localparam int IDXW = CNTW - LOGC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VLEN-1:0]       in_src,
    input  logic [VLEN-1:0]       in_vmask,
    input  logic                  in_vm,
    input  logic [CNTW-1:0]       in_vl,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHUNK*CNTW-1:0] out_data,
    output logic [CHUNK-1:0]      out_we,
    output logic [IDXW-1:0]       out_idx,
    output logic                  out_last,
    output logic [CNTW-1:0]       out_cpop
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // FSM state; kept as a plain named register so checkers can bind to it
    logic [0:0] state;

    // Operation registers captured at acceptance
    logic [VLEN-1:0] src_q;      // mask source
    logic [VLEN-1:0] act_q;      // per-element active flags (vl and v0 folded in)
    logic            mode_q;     // 0 = viota, 1 = vid
    logic [IDXW-1:0] lastc_q;    // index of the final chunk

    // Running state
    logic [IDXW-1:0] chunk_q;    // next chunk to load into the output stage
    logic [CNTW-1:0] acc_q;      // active set bits in all chunks already loaded

    // Request decode
    logic [CNTW-1:0] veff_in;
    logic [VLEN-1:0] act_in;
    logic [IDXW-1:0] lastc_in;

    // Handshake events
    logic accept;
    logic consume;
    logic advance;
    logic finish;
    logic load;

    // Chunk source selection: at acceptance the first chunk is built directly
    // from the request so the beat is ready one cycle later
    logic [VLEN-1:0] sel_src;
    logic [VLEN-1:0] sel_act;
    logic            sel_mode;
    logic [IDXW-1:0] sel_lastc;
    logic [IDXW-1:0] sel_chunk;
    logic [CNTW-1:0] sel_acc;

    // Chunk computation results
    logic [CHUNK-1:0]      src_c;
    logic [CHUNK-1:0]      act_c;
    logic [CHUNK*CNTW-1:0] data_n;
    logic [CNTW-1:0]       acc_n;
    logic                  last_n;
    logic [CNTW-1:0]       cpop_n;

    assign in_ready = (state == S_IDLE) && !flush;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign advance  = (state == S_RUN) && consume && !out_last;
    assign finish   = (state == S_RUN) && consume && out_last;
    assign load     = accept || advance;

    // Decode a request: clamp vl, form active flags, find the final chunk
    always_comb begin
        veff_in = (in_vl > CNTW'(VLEN)) ? CNTW'(VLEN) : in_vl;
        act_in  = '0;
        for (int i = 0; i < VLEN; i++) begin
            act_in[i] = (CNTW'(i) < veff_in) && (in_vm || in_vmask[i]);
        end
        // vl = 0 still produces one (empty) beat, so the final chunk is 0
        if (veff_in == '0) begin
            lastc_in = '0;
        end else begin
            lastc_in = IDXW'((veff_in - CNTW'(1)) >> LOGC);
        end
    end

    // Pick the operand set for the chunk about to be loaded
    always_comb begin
        if (accept) begin
            sel_src   = in_src;
            sel_act   = act_in;
            sel_mode  = in_mode;
            sel_lastc = lastc_in;
            sel_chunk = '0;
            sel_acc   = '0;
        end else begin
            sel_src   = src_q;
            sel_act   = act_q;
            sel_mode  = mode_q;
            sel_lastc = lastc_q;
            sel_chunk = chunk_q;
            sel_acc   = acc_q;
        end
    end

    // Build one chunk: exclusive prefix count on top of the accumulator
    always_comb begin
        logic [CNTW-1:0] run;
        src_c  = CHUNK'(sel_src >> {sel_chunk, {LOGC{1'b0}}});
        act_c  = CHUNK'(sel_act >> {sel_chunk, {LOGC{1'b0}}});
        data_n = '0;
        run    = sel_acc;
        for (int e = 0; e < CHUNK; e++) begin
            if (act_c[e]) begin
                // vid: element index is simply {chunk, lane}
                data_n[e*CNTW +: CNTW] = sel_mode ? {sel_chunk, LOGC'(e)} : run;
            end
            run = run + CNTW'(src_c[e] & act_c[e]);
        end
        acc_n  = run;
        last_n = (sel_chunk == sel_lastc);
        // Total count is reported on the final beat only, in both modes
        cpop_n = last_n ? run : '0;
    end

    // FSM: IDLE accepts a request, RUN streams beats until the last is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (accept) begin
            state <= S_RUN;
        end else if (finish) begin
            state <= S_IDLE;
        end
    end

    // Capture the request operands on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            act_q   <= '0;
            mode_q  <= 1'b0;
            lastc_q <= '0;
        end else if (accept) begin
            src_q   <= in_src;
            act_q   <= act_in;
            mode_q  <= in_mode;
            lastc_q <= lastc_in;
        end
    end

    // Chunk counter and running accumulator step with each output load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunk_q <= '0;
            acc_q   <= '0;
        end else if (flush) begin
            chunk_q <= '0;
            acc_q   <= '0;
        end else if (load) begin
            chunk_q <= sel_chunk + IDXW'(1);
            acc_q   <= acc_n;
        end else if (finish) begin
            chunk_q <= '0;
            acc_q   <= '0;
        end
    end

    // Output stage: reload on acceptance or when a non-final beat is taken,
    // drain after the final beat, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_we    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cpop  <= '0;
        end else if (flush || finish) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_we    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cpop  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= data_n;
            out_we    <= act_c;
            out_idx   <= sel_chunk;
            out_last  <= last_n;
            out_cpop  <= cpop_n;
        end
    end

endmodule
